// File: rtl/rtr_next_hop_sched_pkg.sv
// Shared types for the next-hop-address scheduler.
// State encoding and VC index width helper.
package rtr_next_hop_sched_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int vc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtr_next_hop_sched_arb.sv
// Round-robin one-hot arbiter; pointer advances past the winner
// only when update_en is high and something was granted.
module rtr_next_hop_sched_arb
    import rtr_next_hop_sched_pkg::*;
#(
    parameter int num_vcs = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [num_vcs-1:0] req,
    input  logic               update_en,
    output logic [num_vcs-1:0] gnt
);

    localparam int VW = vc_w(num_vcs);

    logic [VW-1:0] ptr_q;
    logic [VW-1:0] ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < num_vcs; i++) begin
            idx = (int'(ptr_q) + i) % num_vcs;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = (idx == num_vcs - 1) ? '0 : VW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (update_en && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rtr_next_hop_sched.sv
// Shares one next-hop-address unit among num_vcs requesters.
// Define RTR_NEXT_HOP_SCHED_FAST_EN to drop ISSUE (1 result/cycle).
module rtr_next_hop_sched
    import rtr_next_hop_sched_pkg::*;
#(
    parameter int num_vcs           = 4,
    parameter int dest_info_width   = 9,
    parameter int lar_info_width    = 4,
    parameter int router_addr_width = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [num_vcs-1:0]                   req_valid,
    input  logic [num_vcs*dest_info_width-1:0]   req_dest_info,
    input  logic [num_vcs*lar_info_width-1:0]    req_lar_info,
    output logic [num_vcs-1:0]                   req_ready,
    output logic [dest_info_width-1:0]           nha_dest_info,
    output logic [lar_info_width-1:0]            nha_lar_info,
    input  logic [router_addr_width-1:0]         nha_next_addr,
    output logic                                 rsp_valid,
    output logic [vc_w(num_vcs)-1:0]             rsp_vc,
    output logic [router_addr_width-1:0]         rsp_addr,
    input  logic                                 rsp_ready
);

    localparam int VW = vc_w(num_vcs);
    localparam int DW = dest_info_width;
    localparam int LW = lar_info_width;
    localparam int AW = router_addr_width;

`ifdef RTR_NEXT_HOP_SCHED_FAST_EN
    localparam state_t ACC_ST = HOLD;
`else
    localparam state_t ACC_ST = ISSUE;
`endif

    state_t          state_q, state_d;
    logic [DW-1:0]   dest_q;
    logic [LW-1:0]   lar_q;
    logic [VW-1:0]   vc_q;
    logic [AW-1:0]   addr_q;
    logic            accept;
    logic            take;
    logic [num_vcs-1:0] gnt;
    logic [DW-1:0]   sel_dest;
    logic [LW-1:0]   sel_lar;
    logic [VW-1:0]   sel_vc;

    assign accept = !reset &&
                    ((state_q == IDLE) ||
                     (state_q == HOLD && rsp_ready));

    rtr_next_hop_sched_arb #(
        .num_vcs   (num_vcs)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .update_en (accept),
        .gnt       (gnt)
    );

    assign req_ready = accept ? gnt : '0;
    assign take      = |req_ready;

    // VC0 occupies the most significant slice of each operand bus.
    always_comb begin
        sel_dest = '0;
        sel_lar  = '0;
        sel_vc   = '0;
        for (int i = 0; i < num_vcs; i++) begin
            if (gnt[i]) begin
                sel_dest = req_dest_info[(num_vcs-1-i)*DW +: DW];
                sel_lar  = req_lar_info[(num_vcs-1-i)*LW +: LW];
                sel_vc   = VW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (take) state_d = ACC_ST;
            ISSUE: state_d = HOLD;
            HOLD:  if (rsp_ready) state_d = take ? ACC_ST : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dest_q  <= '0;
            lar_q   <= '0;
            vc_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                dest_q <= sel_dest;
                lar_q  <= sel_lar;
                vc_q   <= sel_vc;
            end
`ifdef RTR_NEXT_HOP_SCHED_FAST_EN
            if (take) addr_q <= nha_next_addr;
`else
            if (state_q == ISSUE) addr_q <= nha_next_addr;
`endif
        end
    end

`ifdef RTR_NEXT_HOP_SCHED_FAST_EN
    assign nha_dest_info = take ? sel_dest : dest_q;
    assign nha_lar_info  = take ? sel_lar  : lar_q;
`else
    assign nha_dest_info = dest_q;
    assign nha_lar_info  = lar_q;
`endif

    assign rsp_valid = (state_q == HOLD);
    assign rsp_vc    = vc_q;
    assign rsp_addr  = addr_q;

endmodule

// File: tb/tb_rtr_next_hop_sched.sv
// Directed per-cycle vector table plus a reset-in-HOLD sequence.
// The shared unit is modelled as dest[3:0] ^ lar.
module tb_rtr_next_hop_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [35:0] req_dest_info;
    logic [15:0] req_lar_info;
    logic [3:0]  req_ready;
    logic [8:0]  nha_dest_info;
    logic [3:0]  nha_lar_info;
    logic [3:0]  nha_next_addr;
    logic        rsp_valid;
    logic [1:0]  rsp_vc;
    logic [3:0]  rsp_addr;
    logic        rsp_ready;

    always #5 clk = ~clk;

    // Per-VC results: VC0=5, VC1=7, VC2=E, VC3=4.
    assign nha_next_addr = nha_dest_info[3:0] ^ nha_lar_info;

    rtr_next_hop_sched dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_dest_info (req_dest_info),
        .req_lar_info  (req_lar_info),
        .req_ready     (req_ready),
        .nha_dest_info (nha_dest_info),
        .nha_lar_info  (nha_lar_info),
        .nha_next_addr (nha_next_addr),
        .rsp_valid     (rsp_valid),
        .rsp_vc        (rsp_vc),
        .rsp_addr      (rsp_addr),
        .rsp_ready     (rsp_ready)
    );

    typedef struct {
        bit         rst;
        logic [3:0] rv;
        bit         rr;
        logic [3:0] ready;
        bit         valid;
        logic [1:0] chk;
        logic [1:0] vc;
        logic [3:0] addr;
        logic [8:0] nha;
    } vec_t;

    vec_t tbl[$];
    int   n_chk;
    int   n_pass;

    function automatic void add(bit rst, logic [3:0] rv, bit rr,
                                logic [3:0] ready, bit valid,
                                logic [1:0] chk, logic [1:0] vc,
                                logic [3:0] addr, logic [8:0] nha);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rr = rr; v.ready = ready;
        v.valid = valid; v.chk = chk; v.vc = vc;
        v.addr = addr; v.nha = nha;
        tbl.push_back(v);
    endfunction

    task automatic check(string name, int row,
                         logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %0h expected %0h",
                      name, row, act, exp);
    endtask

    initial begin
        bit found;
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_dest_info = {9'h105, 9'h0A6, 9'h1C7, 9'h038};
        req_lar_info  = {4'h0, 4'h1, 4'h9, 4'hC};

`ifdef RTR_NEXT_HOP_SCHED_FAST_EN
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b0110, 1, 4'b0010, 0, 2, 0, 4'h0, 9'h0A6);
        add(0, 4'b0110, 1, 4'b0100, 1, 3, 1, 4'h7, 9'h1C7);
        add(0, 4'b0110, 1, 4'b0010, 1, 3, 2, 4'hE, 9'h0A6);
        add(0, 4'b0110, 1, 4'b0100, 1, 1, 1, 4'h7, 9'h000);
        add(0, 4'b0000, 1, 4'b0000, 1, 1, 2, 4'hE, 9'h000);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'h0, 9'h000);
`else
        // single request, reset values
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b0000, 0, 4'b0000, 0, 3, 0, 4'h0, 9'h000);
        add(0, 4'b0001, 0, 4'b0001, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b0000, 0, 4'b0000, 0, 2, 0, 4'h0, 9'h105);
        add(0, 4'b0000, 0, 4'b0000, 1, 1, 0, 4'h5, 9'h000);
        add(0, 4'b0000, 1, 4'b0000, 1, 1, 0, 4'h5, 9'h000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'h0, 9'h000);
        // round-robin 0,1,2,3,0 then 5-cycle stall
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b1111, 1, 4'b0001, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b1111, 1, 4'b0000, 0, 2, 0, 4'h0, 9'h105);
        add(0, 4'b1111, 1, 4'b0010, 1, 1, 0, 4'h5, 9'h000);
        add(0, 4'b1111, 1, 4'b0000, 0, 2, 0, 4'h0, 9'h0A6);
        add(0, 4'b1111, 1, 4'b0100, 1, 1, 1, 4'h7, 9'h000);
        add(0, 4'b1111, 1, 4'b0000, 0, 2, 0, 4'h0, 9'h1C7);
        add(0, 4'b1111, 1, 4'b1000, 1, 1, 2, 4'hE, 9'h000);
        add(0, 4'b1111, 1, 4'b0000, 0, 2, 0, 4'h0, 9'h038);
        add(0, 4'b1111, 1, 4'b0001, 1, 1, 3, 4'h4, 9'h000);
        add(0, 4'b1111, 1, 4'b0000, 0, 2, 0, 4'h0, 9'h105);
        for (int k = 0; k < 5; k++)
            add(0, 4'b1111, 0, 4'b0000, 1, 1, 0, 4'h5, 9'h000);
        add(0, 4'b1111, 1, 4'b0010, 1, 1, 0, 4'h5, 9'h000);
        add(0, 4'b0000, 0, 4'b0000, 0, 2, 0, 4'h0, 9'h0A6);
        add(0, 4'b0000, 1, 4'b0000, 1, 1, 1, 4'h7, 9'h000);
        // reset during ISSUE
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b1111, 1, 4'b0001, 0, 0, 0, 4'h0, 9'h000);
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b0000, 1, 4'b0000, 0, 1, 0, 4'h0, 9'h000);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b1111, 1, 4'b0001, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b0000, 0, 4'b0000, 0, 2, 0, 4'h0, 9'h105);
        add(0, 4'b0000, 1, 4'b0000, 1, 1, 0, 4'h5, 9'h000);
        // VC2 withdraws before an eligible accept
        add(0, 4'b0010, 1, 4'b0010, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b0100, 0, 4'b0000, 0, 2, 0, 4'h0, 9'h0A6);
        add(0, 4'b0000, 1, 4'b0000, 1, 1, 1, 4'h7, 9'h000);
        add(0, 4'b0101, 1, 4'b0100, 0, 0, 0, 4'h0, 9'h000);
        add(0, 4'b0000, 0, 4'b0000, 0, 2, 0, 4'h0, 9'h1C7);
        add(0, 4'b0000, 1, 4'b0000, 1, 1, 2, 4'hE, 9'h000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'h0, 9'h000);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            reset     = tbl[i].rst;
            req_valid = tbl[i].rv;
            rsp_ready = tbl[i].rr;
            @(negedge clk);
            if (!tbl[i].rst) begin
                check("req_ready", i, 32'(req_ready), 32'(tbl[i].ready));
                check("rsp_valid", i, 32'(rsp_valid), 32'(tbl[i].valid));
                if (tbl[i].chk[0]) begin
                    check("rsp_vc", i, 32'(rsp_vc), 32'(tbl[i].vc));
                    check("rsp_addr", i, 32'(rsp_addr), 32'(tbl[i].addr));
                end
                if (tbl[i].chk[1])
                    check("nha_dest", i, 32'(nha_dest_info), 32'(tbl[i].nha));
            end
        end

        // reset while a response is held discards it
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("hold_reached", 100, 32'(found), 32'd1);
        check("hold_addr", 100, 32'(rsp_addr), 32'h5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 101, 32'(rsp_valid), 32'd0);
        check("rst_addr", 101, 32'(rsp_addr), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_ptr", 102, 32'(req_ready), 32'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
